// File: rtl/strassen_pkg.sv
// Shared definitions for the Strassen result-matrix readout path.
package strassen_pkg;

  localparam int unsigned NUM_WORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    IDX_C11 = 2'd0,
    IDX_C12 = 2'd1,
    IDX_C21 = 2'd2,
    IDX_C22 = 2'd3
  } elem_idx_e;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO; head is visible on rdata_o while not empty.
module sync_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/strassen_result_reader.sv
// Reads the four C-matrix elements from result memory and streams them
// out with valid/ready, buffering returned words in a 2-entry FIFO.
module strassen_result_reader
  import strassen_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned BASE_ADDR = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_idx,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned FW = DATA_W + 2;

  state_e      state_q, state_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic        rd_pend_q;
  logic [1:0]  rd_idx_q;

  logic [FW-1:0] fifo_wdata;
  logic [FW-1:0] fifo_rdata;
  logic          fifo_empty;
  logic [1:0]    fifo_count;
  logic          xfer;
  logic [2:0]    credit_used;
  logic          can_issue;

  assign fifo_wdata = {rd_idx_q, mem_rdata};

  sync_fifo2 #(
    .W(FW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rd_pend_q),
    .wdata_i (fifo_wdata),
    .pop_i   (xfer),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata[DATA_W-1:0];
  assign out_idx   = fifo_rdata[DATA_W +: 2];
  assign out_last  = out_valid && (out_idx == IDX_C22);
  assign xfer      = out_valid && out_ready;

  // Occupancy is taken after this cycle's pop so the stream runs back-to-back.
  assign credit_used = {1'b0, fifo_count} - {2'b00, xfer} + {2'b00, rd_pend_q};
  assign can_issue   = (issue_cnt_q < 3'(NUM_WORDS)) && (credit_used < 3'd2);

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    mem_re      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_READ;
          issue_cnt_d = '0;
        end
      end
      ST_READ: begin
        if (can_issue) begin
          mem_re      = 1'b1;
          issue_cnt_d = issue_cnt_q + 3'd1;
          if (issue_cnt_q == 3'(NUM_WORDS - 1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (xfer && out_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_addr = mem_re ? (ADDR_W'(BASE_ADDR) + ADDR_W'(issue_cnt_q)) : '0;
  assign busy     = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rd_pend_q   <= mem_re;
      if (mem_re) begin
        rd_idx_q <= issue_cnt_q[1:0];
      end
    end
  end

endmodule

// File: tb/tb_strassen_result_reader.sv
// Directed bench: default instance (base 8) plus a base-14 instance for wrap.
module tb_strassen_result_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, out_ready;

  logic        a_re, a_last, a_valid, a_busy, a_done;
  logic [3:0]  a_addr;
  logic [15:0] a_rdata, a_data;
  logic [1:0]  a_idx;

  logic        b_re, b_last, b_valid, b_busy, b_done;
  logic [3:0]  b_addr;
  logic [15:0] b_rdata, b_data;
  logic [1:0]  b_idx;

  logic [15:0] mem [16];

  int tests = 0;
  int fails = 0;

  strassen_result_reader #(.DATA_W(16), .ADDR_W(4), .BASE_ADDR(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_re(a_re), .mem_addr(a_addr), .mem_rdata(a_rdata),
    .out_data(a_data), .out_idx(a_idx), .out_last(a_last),
    .out_valid(a_valid), .out_ready(out_ready),
    .busy(a_busy), .done(a_done)
  );

  strassen_result_reader #(.DATA_W(16), .ADDR_W(4), .BASE_ADDR(14)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_re(b_re), .mem_addr(b_addr), .mem_rdata(b_rdata),
    .out_data(b_data), .out_idx(b_idx), .out_last(b_last),
    .out_valid(b_valid), .out_ready(out_ready),
    .busy(b_busy), .done(b_done)
  );

  always @(posedge clk) begin
    a_rdata <= a_re ? mem[a_addr] : 16'hDEAD;
    b_rdata <= b_re ? mem[b_addr] : 16'hDEAD;
  end

  // Cycle table for the basic readout, index = cycle relative to start.
  int exp_re[9]    = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
  int exp_aaddr[9] = '{0, 8, 9, 10, 11, 0, 0, 0, 0};
  int exp_baddr[9] = '{0, 14, 15, 0, 1, 0, 0, 0, 0};
  int exp_ov[9]    = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
  int exp_ad[9]    = '{0, 0, 0, 'h0011, 'h0022, 'h0033, 'h0044, 0, 0};
  int exp_bd[9]    = '{0, 0, 0, 'h0A0E, 'h0A0F, 'h0A00, 'h0A01, 0, 0};
  int exp_idx[9]   = '{0, 0, 0, 0, 1, 2, 3, 0, 0};
  int exp_last[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
  int exp_done[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
  int exp_busy[9]  = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
  int exp_word[4]  = '{'h0011, 'h0022, 'h0033, 'h0044};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_a_re",    {31'd0, a_re},    0);
    chk("rst_a_addr",  {28'd0, a_addr},  0);
    chk("rst_a_valid", {31'd0, a_valid}, 0);
    chk("rst_a_data",  {16'd0, a_data},  0);
    chk("rst_a_idx",   {30'd0, a_idx},   0);
    chk("rst_a_last",  {31'd0, a_last},  0);
    chk("rst_a_busy",  {31'd0, a_busy},  0);
    chk("rst_a_done",  {31'd0, a_done},  0);
    chk("rst_b_valid", {31'd0, b_valid}, 0);
    rst_n = 1'b1;
  endtask

  // mode 0: ready always high; 1: ready low in cycles 0-9;
  // 2: ready toggles 1,0,1,0; 3: ready high and a second start in cycle 2.
  task automatic run_readout(input int mode, input string name);
    int          xfers = 0, dones = 0, reads = 0, reads_early = 0;
    int          last_xfer_cyc = -10, done_cyc = -1;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic [1:0]  prev_idx = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = (c == 0) || (mode == 3 && c == 2);
      case (mode)
        1:       out_ready = (c >= 10);
        2:       out_ready = (c % 2 == 0);
        default: out_ready = 1'b1;
      endcase
      #1;
      if (a_re) begin
        chk({name, "_addr"}, {28'd0, a_addr}, 32'(8 + reads));
        reads++;
        if (c < 10) reads_early++;
      end
      if (mode == 1 && c == 9) begin
        chk({name, "_stall_valid"}, {31'd0, a_valid}, 1);
        chk({name, "_stall_data"}, {16'd0, a_data}, 'h0011);
      end
      if (a_valid) begin
        if (prev_stall) begin
          chk({name, "_hold_data"}, {16'd0, a_data}, {16'd0, prev_data});
          chk({name, "_hold_idx"}, {30'd0, a_idx}, {30'd0, prev_idx});
        end
        if (out_ready) begin
          if (xfers < 4) begin
            chk({name, "_data"}, {16'd0, a_data}, exp_word[xfers]);
            chk({name, "_idx"}, {30'd0, a_idx}, 32'(xfers));
            chk({name, "_last"}, {31'd0, a_last}, (xfers == 3) ? 1 : 0);
          end else begin
            chk({name, "_extra_xfer"}, 1, 0);
          end
          xfers++;
          last_xfer_cyc = c;
        end
      end
      prev_stall = a_valid && !out_ready;
      prev_data  = a_data;
      prev_idx   = a_idx;
      if (a_done) begin
        dones++;
        done_cyc = c;
        chk({name, "_done_busy"}, {31'd0, a_busy}, 0);
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk({name, "_reads"}, 32'(reads), 4);
    chk({name, "_xfers"}, 32'(xfers), 4);
    chk({name, "_dones"}, 32'(dones), 1);
    chk({name, "_done_cyc"}, 32'(done_cyc), 32'(last_xfer_cyc + 1));
    if (mode == 1) chk({name, "_reads_before_ready"}, 32'(reads_early), 2);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0A00 + 16'(i);
    mem[8]  = 16'h0011;
    mem[9]  = 16'h0022;
    mem[10] = 16'h0033;
    mem[11] = 16'h0044;

    do_reset();

    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      start     = (c == 0);
      out_ready = 1'b1;
      #1;
      chk("t1_a_re",   {31'd0, a_re},    exp_re[c]);
      chk("t1_a_ov",   {31'd0, a_valid}, exp_ov[c]);
      chk("t1_a_done", {31'd0, a_done},  exp_done[c]);
      chk("t1_a_busy", {31'd0, a_busy},  exp_busy[c]);
      chk("t1_b_re",   {31'd0, b_re},    exp_re[c]);
      chk("t1_b_ov",   {31'd0, b_valid}, exp_ov[c]);
      chk("t1_b_done", {31'd0, b_done},  exp_done[c]);
      chk("t1_b_busy", {31'd0, b_busy},  exp_busy[c]);
      if (exp_re[c] != 0) begin
        chk("t1_a_addr", {28'd0, a_addr}, exp_aaddr[c]);
        chk("t1_b_addr", {28'd0, b_addr}, exp_baddr[c]);
      end
      if (exp_ov[c] != 0) begin
        chk("t1_a_data", {16'd0, a_data}, exp_ad[c]);
        chk("t1_a_idx",  {30'd0, a_idx},  exp_idx[c]);
        chk("t1_a_last", {31'd0, a_last}, exp_last[c]);
        chk("t1_b_data", {16'd0, b_data}, exp_bd[c]);
        chk("t1_b_idx",  {30'd0, b_idx},  exp_idx[c]);
        chk("t1_b_last", {31'd0, b_last}, exp_last[c]);
      end
    end
    start = 1'b0;

    run_readout(1, "stall");
    run_readout(2, "toggle");
    run_readout(3, "restart");

    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start     = (c == 0);
      out_ready = 1'b1;
      if (c == 4) rst_n = 1'b0;
      #1;
      if (c == 5) begin
        chk("midrst_valid", {31'd0, a_valid}, 0);
        chk("midrst_busy",  {31'd0, a_busy},  0);
        chk("midrst_done",  {31'd0, a_done},  0);
        chk("midrst_re",    {31'd0, a_re},    0);
        chk("midrst_data",  {16'd0, a_data},  0);
        rst_n = 1'b1;
      end
    end
    start = 1'b0;
    run_readout(0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/strassen_result_reader.md
STRASSEN_RESULT_READER -- requirements
Module: strassen_result_reader

Interface
REQ-001 Parameter DATA_W, default 16: width of one result-matrix element.
REQ-002 Parameter ADDR_W, default 4: result-memory address width.
REQ-003 Parameter BASE_ADDR, default 8: address of the C11 element; C12, C21 and C22 follow at +1, +2 and +3.
REQ-004 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: one-cycle request to read out the 2x2 result matrix.
REQ-007 Port mem_re, output, 1 bit: result-memory read enable.
REQ-008 Port mem_addr, output, ADDR_W bits: result-memory read address; valid while mem_re is high.
REQ-009 Port mem_rdata, input, DATA_W bits: read data, valid exactly one cycle after mem_re.
REQ-010 Port out_data, output, DATA_W bits: streamed result element.
REQ-011 Port out_idx, output, 2 bits: element index (0=C11, 1=C12, 2=C21, 3=C22).
REQ-012 Port out_last, output, 1 bit: high with element index 3.
REQ-013 Port out_valid, output, 1 bit: out_data, out_idx and out_last are valid.
REQ-014 Port out_ready, input, 1 bit: downstream accepts the element.
REQ-015 Port busy, output, 1 bit: a readout is in progress.
REQ-016 Port done, output, 1 bit: one-cycle pulse marking the end of a readout.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, DRAIN and DONE, all registered.
REQ-018 IDLE->READ SHALL occur when start is sampled high; busy SHALL be high from the next cycle.
REQ-019 In READ, mem_re SHALL be asserted, with mem_addr = BASE_ADDR + issue count, only when issue count < 4 and (FIFO occupancy + reads in flight) < 2.
REQ-020 The first mem_re SHALL occur in cycle S+1, where S is the cycle in which start is sampled high; the data SHALL be written to the FIFO at the end of S+2, and out_valid SHALL be high in S+3.
REQ-021 Returned data SHALL be pushed into a 2-entry FIFO, tagged with its index.
REQ-022 The FIFO head SHALL drive out_data, out_idx and out_last; out_valid SHALL equal FIFO-not-empty.
REQ-023 A transfer SHALL occur when out_valid && out_ready; out_data, out_idx and out_last SHALL be held stable while out_valid && !out_ready.
REQ-024 With out_ready held high, the block SHALL sustain one element per cycle after the first.
REQ-025 READ->DRAIN SHALL occur after the fourth mem_re.
REQ-026 DRAIN->DONE SHALL occur on the transfer with out_last=1.
REQ-027 In DONE, done SHALL be high for exactly one cycle and busy SHALL be low, followed by DONE->IDLE.
REQ-028 start asserted while busy or in DONE SHALL be ignored, with no effect on the sequence.
REQ-029 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged; the FIFO SHALL never overflow, which the credit rule of REQ-019 guarantees.
REQ-030 The issue counter SHALL be 3 bits; address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-031 While rst_n is low, the block SHALL be in IDLE, with the FIFO empty, counters zero, and mem_re, out_valid, busy and done all 0.
REQ-032 The outputs mem_addr, out_data, out_idx and out_last SHALL be 0 in reset.
REQ-033 Reset mid-readout SHALL abort immediately, and read data returned after reset deasserts SHALL be discarded.

Structure
REQ-034 The state enum, the element-index encoding and the NUM_WORDS=4 constant SHALL reside in the shared package strassen_pkg.
REQ-035 The 2-entry FIFO SHALL be a separate sub-module, sync_fifo2, parameterised by data width.

Verification
REQ-036 Memory 8..11 = 0x0011, 0x0022, 0x0033, 0x0044; start at cycle 0 with out_ready=1 -> mem_re in cycles 1-4 with addresses 8-11; outputs in cycles 3-6 with idx 0-3; out_last in cycle 6; done in cycle 7.
REQ-037 Same data, out_ready low in cycles 0-9 then high -> at most 2 reads issued before the stall; stable 0x0011 held; all four words in order; done after the last.
REQ-038 out_ready toggling 1,0,1,0 -> each word delivered once with no duplication or loss; idx sequence 0, 1, 2, 3.
REQ-039 start pulsed again in cycle 2 -> no extra mem_re and exactly one done.
REQ-040 rst_n low in cycle 4 -> in cycle 5, out_valid=0, busy=0 and the FIFO is empty; a new start then reads 0x0011 first.
REQ-041 BASE_ADDR=14, ADDR_W=4 -> addresses 14, 15, 0, 1.
